// File: rtl/divide_if.sv
// Operand/result bundle for the sequential divider, shared by the
// instruction sequencer (master) and the divider itself (slave).
interface divide_if;
  logic [23:0] dividend;
  logic [11:0] divisor;
  logic        start;
  logic [11:0] quotient;
  logic [11:0] remainder;
  logic        overflow;
  logic        finished;

  modport master (
    output dividend, divisor, start,
    input  quotient, remainder, overflow, finished
  );

  modport slave (
    input  dividend, divisor, start,
    output quotient, remainder, overflow, finished
  );
endinterface

// File: rtl/divide.sv
// Restoring 24/12 divider for DVI: 12 iterations, overflow (including a zero
// divisor) is caught at load time and leaves the operands in place.
module divide (
  input  logic     clock,
  input  logic     reset,
  divide_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] rq_q, rq_d;
  logic [11:0] dv_q, dv_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [12:0] p;
  logic        no_borrow;
  logic [11:0] diff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rq_q    <= 24'd0;
      dv_q    <= 12'd0;
      ovf_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rq_q    <= rq_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // R < dv is guaranteed, so a successful subtract always fits in 12 bits.
  always_comb begin
    p         = {rq_q[23:12], rq_q[11]};
    no_borrow = (p >= {1'b0, dv_q});
    diff      = p[11:0] - dv_q;
  end

  always_comb begin
    state_d = state_q;
    rq_d    = rq_q;
    dv_d    = dv_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rq_d    = bus.dividend;
          dv_d    = bus.divisor;
          cnt_d   = 4'd0;
          ovf_d   = (bus.dividend[23:12] >= bus.divisor);
          state_d = (bus.dividend[23:12] >= bus.divisor) ? DONE : DIV;
        end
      end
      DIV: begin
        if (no_borrow) begin
          rq_d = {diff, rq_q[10:0], 1'b1};
        end else begin
          rq_d = {p[11:0], rq_q[10:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd11) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A held request must drop before another load can happen.
        if (!bus.start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.quotient  = rq_q[11:0];
  assign bus.remainder = rq_q[23:12];
  assign bus.overflow  = ovf_q;
  assign bus.finished  = (state_q == DONE);

endmodule

// File: doc/divide.md
# divide

Sequential restoring divider for the extended arithmetic path: divides a 24-bit unsigned dividend by a 12-bit unsigned divisor, producing a 12-bit quotient and 12-bit remainder in 12 iteration cycles. It is the DVI counterpart of the shift-add multiplier. It is driven by the same start/finished handshake from the instruction sequencer, and operands arrive as the AC:MQ pair and the memory operand. Overflow, meaning a quotient that will not fit in 12 bits or a zero divisor, is detected at load time and reported without iterating.

## Interface
Parameters: none (widths fixed by the PDP-8 word size).
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- dividend  in  24  unsigned dividend, {AC, MQ}; sampled only on the load edge
- divisor  in  12  unsigned divisor; sampled only on the load edge
- start  in  1  request; level-sampled in IDLE
- quotient  out  12  quotient; valid while finished=1
- remainder  out  12  remainder; valid while finished=1
- overflow  out  1  divide overflow (dividend[23:12] >= divisor, incl. divisor=0); valid while finished=1
- finished  out  1  result valid; decode of state DONE

## Operation
- Internal registers:
  - rq[23:0]: remainder:quotient working pair, with rq[23:12]=R and rq[11:0]=Q.
  - dv[11:0]: latched divisor.
  - ovf: overflow flag.
  - cnt: iteration counter, 4 bits minimum.
- FSM states IDLE, DIV, DONE. Reset sets state=IDLE, rq=0, dv=0, ovf=0, cnt=0. All outputs read 0 after reset.
- IDLE with start=1 is the load edge:
  - rq<=dividend, dv<=divisor, cnt<=0.
  - ovf<=(dividend[23:12] >= divisor), a 12-bit unsigned compare.
  - If the compare is true, next state is DONE. Otherwise next state is DIV.
- IDLE with start=0 holds all registers.
- DIV performs one iteration per cycle:
  - p[12:0] = {R, Q[11]}.
  - t[13:0] = {1'b0,p} - {2'b0,dv}.
  - If t[13]=0 (no borrow): R<=t[11:0] and Q<={Q[10:0],1}.
  - Otherwise: R<=p[11:0] and Q<={Q[10:0],0}.
  - cnt<=cnt+1. Exit to DONE on the edge where cnt==11, i.e. after exactly 12 iterations.
- R<divisor holds throughout the iterations, guaranteed by the load check, so p<2*dv and the new R always fits 12 bits.
- quotient=rq[11:0], remainder=rq[23:12], overflow=ovf. These outputs are driven continuously; mid-iteration values are don't-care.
- On overflow no iteration runs, so the outputs are quotient=dividend[11:0], remainder=dividend[23:12], overflow=1. This leaves the operands unchanged for software, per PDP-8 DVI.
- DONE:
  - finished=1 and registers hold.
  - start=1 stays in DONE, so a held request does not retrigger.
  - start=0 goes to IDLE on the next edge.
- start is ignored in DIV.
- Invariant: no new load is possible until start has been seen low in DONE.
- Reset asserted at any time, including mid-DIV, returns immediately (asynchronously) to the reset state. There is no partial result.

## Timing
- Let E0 be the rising edge sampling start=1 in IDLE.
- Normal divide:
  - E1..E12 are the iteration edges.
  - finished rises after E12, i.e. 12 cycles after the load cycle.
- Overflow: finished rises after E0, so it is visible in the cycle after the load cycle.
- finished falls on the first edge at which start=0 is sampled in DONE.
- Minimum start-to-start spacing for back-to-back normal divides is 15 edges: load, 12 iterations, DONE with start low, then IDLE sampling start high.
- Results stay stable from finished rising until the next load edge, including through IDLE.
- No combinational path from inputs to outputs. finished is a decode of registered state only.

## Test plan
- Basic divide: dividend=24'd100, divisor=12'd7, start pulsed until finished -> quotient=14, remainder=2, overflow=0; finished first seen high 12 cycles after the load cycle.
- Maximum quotient: dividend=24'h7FFFFF, divisor=12'hFFF -> quotient=12'h800, remainder=12'h7FF, overflow=0.
- Overflow cases:
  - dividend=24'h005000, divisor=12'h005 -> overflow=1, quotient=12'h000, remainder=12'h005, finished one cycle after load.
  - divisor=0, dividend=24'h000123 -> overflow=1, quotient=12'h123, remainder=12'h000.
- Handshake:
  - Hold start=1 for 30 cycles -> exactly one load; finished stays 1 until start drops, then clears on the next edge.
  - Toggle start during DIV -> result unaffected.
- Reset mid-operation: assert reset after iteration 6 -> all outputs 0 immediately. After release, 100/7 again yields 14 r 2.
- Random: 10k random dividend/divisor pairs against a reference model -> verify quotient, remainder, overflow and latency (12 or 0 iterations).
